// File: rtl/pc_pkg.sv
// pc_pkg: shared state type, step sizes and alignment check for pc_unit.
// Macro PC_COMPRESSED_EN selects 2-byte (RVC) alignment instead of 4-byte.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } pc_state_t;

  localparam int PC_STEP4 = 4;
  localparam int PC_STEP2 = 2;

  function automatic logic pc_misaligned(
    input logic [1:0] lsb
  );
`ifdef PC_COMPRESSED_EN
    return lsb[0];
`else
    return |lsb;
`endif
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch address handshake between pc_unit and instruction fetch.
// master drives fetch_valid/pc/pc_plus4, slave returns fetch_ready.
interface pc_unit_if #(
  parameter int XLEN = 32
);

  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;

  modport master (
    output fetch_valid,
    output pc,
    output pc_plus4,
    input  fetch_ready
  );

  modport slave (
    input  fetch_valid,
    input  pc,
    input  pc_plus4,
    output fetch_ready
  );

endinterface

// File: rtl/pc_target_calc.sv
// pc_target_calc: redirect target = base + imm, JALR clears bit 0.
// Ports: base, imm, is_jalr in; tgt, misaligned out (combinational).
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] base,
  input  logic [XLEN-1:0] imm,
  input  logic            is_jalr,
  output logic [XLEN-1:0] tgt,
  output logic            misaligned
);

  logic [XLEN-1:0] sum;

  assign sum = base + imm;
  assign tgt = {sum[XLEN-1:1], sum[0] & ~is_jalr};
  assign misaligned = pc_misaligned(tgt[1:0]);

endmodule

// File: rtl/pc_unit.sv
// pc_unit: PC register, BOOT/RUN/HALTED FSM, redirect/trap vectoring and
// fetch counter. Ports: clk, reset (async low), fetch (pc_unit_if.master),
// stall, redirect_*, trap, halt, resume, misalign_err, bad_addr, halted,
// fetch_count. PC_COMPRESSED_EN adds instr_is_16 (+2 step, 2-byte align).
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = 'h100,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  pc_unit_if.master        fetch,
`ifdef PC_COMPRESSED_EN
  input  logic             instr_is_16,
`endif
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic             redirect_is_jalr,
  input  logic [XLEN-1:0]  redirect_base,
  input  logic [XLEN-1:0]  redirect_imm,
  input  logic             trap,
  input  logic             halt,
  input  logic             resume,
  output logic             misalign_err,
  output logic [XLEN-1:0]  bad_addr,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] bad_d;
  logic            mis_d;
  logic [XLEN-1:0] step;
  logic [XLEN-1:0] tgt;
  logic            tgt_mis;
  logic            run;

`ifdef PC_COMPRESSED_EN
  assign step = instr_is_16 ? XLEN'(PC_STEP2)
                            : XLEN'(PC_STEP4);
`else
  assign step = XLEN'(PC_STEP4);
`endif

  pc_target_calc #(
    .XLEN(XLEN)
  ) u_tgt (
    .base      (redirect_base),
    .imm       (redirect_imm),
    .is_jalr   (redirect_is_jalr),
    .tgt       (tgt),
    .misaligned(tgt_mis)
  );

  assign run               = (state_q == RUN);
  assign fetch.fetch_valid = run;
  assign fetch.pc          = pc_q;
  assign fetch.pc_plus4    = pc_q + step;
  assign halted            = (state_q == HALTED);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bad_d   = bad_addr;
    mis_d   = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (trap) begin
          pc_d = TRAP_VEC;
        end else if (redirect_valid) begin
          if (tgt_mis) begin
            pc_d  = TRAP_VEC;
            mis_d = 1'b1;
            bad_d = tgt;
          end else begin
            pc_d = tgt;
          end
        end else if (!halt && fetch.fetch_ready
                     && !stall) begin
          pc_d = fetch.pc_plus4;
        end
        // halt still lets a same-cycle flush land
        if (halt) state_d = HALTED;
      end
      HALTED: begin
        if (resume && !halt) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VEC;
      misalign_err <= 1'b0;
      bad_addr     <= '0;
      fetch_count  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      misalign_err <= mis_d;
      bad_addr     <= bad_d;
      if (run && fetch.fetch_ready)
        fetch_count <= fetch_count + CNT_W'(1);
    end
  end

endmodule
